// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: opcode constants, the fetch
// handshake state type and fetch-related defaults.
package mips_pkg;

  // Primary opcodes seen by the control decoder (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Fixed instruction word width and the byte step between instructions.
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned PC_STEP   = 4;

  // Default fetch address after reset; must be word aligned.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Two-phase fetch handshake: request a word, then execute it.
  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fetch_state_t;

  // Branch displacement in bytes: the 16-bit word offset shifted left by two,
  // sign-extended to 32 bits. Callers resize it signed to the PC width.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: jump beats taken branch beats fall-through.
// The jump form keeps the top four bits of pc_plus4, so ADDR_W must exceed 28.
module pc_next
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  // Only the low 26 bits of the instruction carry target / offset fields.
  input  logic [25:0]       instr,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_target;
  logic signed [31:0] disp;

  assign disp          = $signed(branch_offset(instr[15:0]));
  // Pseudo-direct jump: region bits from pc_plus4, word index from the instruction.
  assign jump_target   = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
  // Adding the signed displacement modulo 2^ADDR_W handles backward branches and wrap.
  assign branch_target = pc_plus4 + ADDR_W'(disp);

  // Priority mux for the PC loaded when the current instruction retires.
  always_comb begin
    // NOTE: next_pc gets a default first so no path through the block leaves it unassigned (no latch).
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch and PC sequencing. A FETCH/EXEC handshake against
// instruction memory latches one instruction, holds it stable while the
// datapath executes (including stalls), then advances the PC using the
// decoder's branch/jump and the ALU zero flag, and counts retirements.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int unsigned      ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic [31:0]        retired
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] next_pc;

  // Address and decoder fields are pure views of the PC and instruction registers,
  // so they stay constant for the whole EXEC residency.
  assign imem_addr = pc;
  assign pc_plus4  = pc + ADDR_W'(PC_STEP);
  assign opcode    = instr[31:26];

  pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc_plus4 (pc_plus4),
    .instr    (instr[25:0]),
    .branch   (branch),
    .zero     (zero),
    .jump     (jump),
    .next_pc  (next_pc)
  );

  // Fetch FSM with registered handshake outputs, PC, instruction and retire counter.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all of them see pre-edge values of each other.
    if (reset) begin
      // Reset abandons any outstanding request and ignores a coincident ack or stall.
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      retired     <= '0;
      imem_req    <= 1'b1;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          // Request and address stay put until memory answers.
          if (imem_ack) begin
            instr       <= imem_rdata;
            state       <= EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          // Control inputs matter only on the cycle the instruction completes.
          if (!stall) begin
            pc          <= next_pc;
            retired     <= retired + 32'd1;
            state       <= FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= FETCH;
          imem_req    <= 1'b1;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: reset behaviour, a table of redirect
// vectors, hand-written stall / ack-delay / mid-operation reset sequences,
// and randomized instruction streams against a behavioural PC model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall, branch, jump, zero;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc, pc_plus4, retired;
  logic [5:0]  opcode;

  // Second instance reset to the top word, for the address wrap case.
  logic        w_imem_req, w_instr_valid;
  logic [31:0] w_imem_addr, w_instr, w_pc, w_pc_plus4, w_retired;
  logic [5:0]  w_opcode;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: just the architectural PC and retire count.
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  instr_fetch dut (
    .clk (clk), .reset (reset),
    .imem_req (imem_req), .imem_addr (imem_addr),
    .imem_ack (imem_ack), .imem_rdata (imem_rdata),
    .stall (stall), .branch (branch), .jump (jump), .zero (zero),
    .instr (instr), .opcode (opcode), .instr_valid (instr_valid),
    .pc (pc), .pc_plus4 (pc_plus4), .retired (retired)
  );

  instr_fetch #(.ADDR_W (32), .RESET_PC (32'hFFFF_FFFC)) dut_w (
    .clk (clk), .reset (reset),
    .imem_req (w_imem_req), .imem_addr (w_imem_addr),
    .imem_ack (imem_ack), .imem_rdata (imem_rdata),
    .stall (stall), .branch (branch), .jump (jump), .zero (zero),
    .instr (w_instr), .opcode (w_opcode), .instr_valid (w_instr_valid),
    .pc (w_pc), .pc_plus4 (w_pc_plus4), .retired (w_retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural next PC from the ISA rules, in plain integer arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                             input logic b, input logic j, input logic z);
    logic [31:0] p4;
    int          imm;
    p4 = cur + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
    if (b && z) begin
      imm = int'(w & 32'h0000_FFFF);
      if (imm >= 32768) imm = imm - 65536;
      return p4 + 32'(imm * 4);
    end
    return p4;
  endfunction

  // Drives the control inputs with junk that the DUT must ignore.
  task automatic junk_controls();
    branch = 1'($urandom);
    jump   = 1'($urandom);
    zero   = 1'($urandom);
  endtask

  // Enters at a falling edge with reset asserted; leaves at a falling edge in FETCH.
  task automatic do_reset();
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    stall      = 1'b1;
    junk_controls();
    @(negedge clk);
    check("rst_req",     32'(imem_req),    32'd1);
    check("rst_addr",    imem_addr,        32'h0);
    check("rst_pc",      pc,               32'h0);
    check("rst_instr",   instr,            32'h0);
    check("rst_opcode",  32'(opcode),      32'h0);
    check("rst_valid",   32'(instr_valid), 32'd0);
    check("rst_retired", retired,          32'h0);
    reset    = 1'b0;
    imem_ack = 1'b0;
    stall    = 1'b0;
    m_pc     = 32'h0;
    m_ret    = 32'h0;
  endtask

  // One complete instruction: ack_dly wait cycles, ack, stall_n stall cycles, retire.
  task automatic run_instr(input logic [31:0] w, input logic b, input logic j, input logic z,
                           input int ack_dly, input int stall_n);
    for (int i = 0; i < ack_dly; i++) begin
      check("wait_req",   32'(imem_req),    32'd1);
      check("wait_addr",  imem_addr,        m_pc);
      check("wait_valid", 32'(instr_valid), 32'd0);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      stall      = 1'($urandom);
      junk_controls();
      @(negedge clk);
    end
    check("fetch_req",  32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr,     m_pc);
    imem_ack   = 1'b1;
    imem_rdata = w;
    stall      = 1'($urandom);
    junk_controls();
    @(negedge clk);
    for (int s = 0; s <= stall_n; s++) begin
      check("exec_valid",   32'(instr_valid), 32'd1);
      check("exec_req",     32'(imem_req),    32'd0);
      check("exec_instr",   instr,            w);
      check("exec_opcode",  32'(opcode),      w >> 26);
      check("exec_pc",      pc,               m_pc);
      check("exec_pc4",     pc_plus4,         m_pc + 32'd4);
      check("exec_retired", retired,          m_ret);
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      if (s < stall_n) begin
        stall = 1'b1;
        junk_controls();
      end else begin
        stall  = 1'b0;
        branch = b;
        jump   = j;
        zero   = z;
      end
      @(negedge clk);
    end
    m_pc  = model_next(m_pc, w, b, j, z);
    m_ret = m_ret + 32'd1;
    check("ret_pc",      pc,               m_pc);
    check("ret_addr",    imem_addr,        m_pc);
    check("ret_retired", retired,          m_ret);
    check("ret_valid",   32'(instr_valid), 32'd0);
    check("ret_req",     32'(imem_req),    32'd1);
    imem_ack = 1'b0;
    stall    = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] word;
    logic        b, j, z;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
    m_pc = '0; m_ret = '0;

    // Redirect vectors, each executed from pc = 0x10.
    vecs[0] = '{"beq_taken",     32'h1000_0003, 1'b1, 1'b0, 1'b1, 32'h0000_0020};
    vecs[1] = '{"beq_not_taken", 32'h1000_0003, 1'b1, 1'b0, 1'b0, 32'h0000_0014};
    vecs[2] = '{"beq_self",      32'h1000_FFFF, 1'b1, 1'b0, 1'b1, 32'h0000_0010};
    vecs[3] = '{"jump_priority", 32'h0800_0040, 1'b1, 1'b1, 1'b1, 32'h0000_0100};
    vecs[4] = '{"zero_no_br",    32'h1000_0003, 1'b0, 1'b0, 1'b1, 32'h0000_0014};
    vecs[5] = '{"beq_min_wrap",  32'h1000_8000, 1'b1, 1'b0, 1'b1, 32'hFFFE_0014};
    vecs[6] = '{"jump_max",      32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0FFF_FFFC};

    @(negedge clk);

    // Reset and first fetch; the wrap instance must step from the top word to 0.
    do_reset();
    check("w_rst_addr", w_imem_addr, 32'hFFFF_FFFC);
    run_instr(32'h2008_0005, 1'b0, 1'b0, 1'b0, 0, 0);
    check("first_pc",    pc,          32'h4);
    check("first_ret",   retired,     32'h1);
    check("wrap_addr",   w_imem_addr, 32'h0);
    check("wrap_pc",     w_pc,        32'h0);

    // Table of redirect cases.
    foreach (vecs[k]) begin
      @(negedge clk);
      reset = 1'b1;
      do_reset();
      for (int n = 0; n < 4; n++) run_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0);
      check({vecs[k].name, "_start"}, pc, 32'h10);
      run_instr(vecs[k].word, vecs[k].b, vecs[k].j, vecs[k].z, 0, 0);
      check(vecs[k].name, pc, vecs[k].exp_pc);
    end

    // Three stall cycles, then an ack delayed by four cycles.
    reset = 1'b1;
    do_reset();
    run_instr(32'h8C43_0008, 1'b0, 1'b0, 1'b0, 0, 3);
    run_instr(32'hAC43_000C, 1'b0, 1'b0, 1'b0, 4, 0);
    check("stall_wait_pc",  pc,      32'h8);
    check("stall_wait_ret", retired, 32'h2);

    // Reset during a FETCH wait with a coincident ack: nothing is latched.
    run_instr(32'h1111_1111, 1'b0, 1'b0, 1'b0, 0, 0);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    do_reset();
    imem_ack = 1'b0;
    @(negedge clk);
    check("midrst_instr", instr,            32'h0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_req",   32'(imem_req),    32'd1);
    check("midrst_addr",  imem_addr,        32'h0);

    // Reset beats stall while an instruction is executing.
    run_instr(32'h2008_0001, 1'b0, 1'b0, 1'b0, 0, 0);
    imem_ack = 1'b1; imem_rdata = 32'h2108_0002;
    @(negedge clk);
    check("midexec_valid", 32'(instr_valid), 32'd1);
    reset = 1'b1;
    do_reset();

    // Randomized instruction stream against the model.
    for (int r = 0; r < 300; r++) begin
      logic [31:0] w;
      logic        b, j, z;
      w = $urandom;
      b = ($urandom_range(0, 1) == 1);
      j = ($urandom_range(0, 3) == 0);
      z = ($urandom_range(0, 1) == 1);
      run_instr(w, b, j, z, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and PC sequencing unit for the MIPS core. It is the upstream end of the main control decoder: it drives the opcode into the decoder and consumes the decoder's `branch` and `jump` outputs, together with the ALU `zero` flag, to choose the next PC. It runs a two-state fetch/execute handshake against instruction memory, holds the current instruction stable for the datapath, and counts retired instructions.

## Interface
Parameters:
- `ADDR_W`, 32, PC and instruction-memory address width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  ADDR_W  fetch address, equal to `pc`.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  datapath hold request; freezes EXEC.
- `branch`  in  1  from the control decoder, for the current instruction.
- `jump`  in  1  from the control decoder, for the current instruction.
- `zero`  in  1  ALU zero flag for the current instruction.
- `instr`  out  32  latched current instruction.
- `opcode`  out  6  `instr[31:26]`, fed to the control decoder.
- `instr_valid`  out  1  `instr` is current and executing.
- `pc`  out  ADDR_W  address of the current instruction.
- `pc_plus4`  out  ADDR_W  `pc + 4`, modulo 2^ADDR_W.
- `retired`  out  32  count of completed instructions.

## Operation
- FSM states: FETCH, EXEC.
- **FETCH**
  - `imem_req=1`, `imem_addr=pc`.
  - Hold the request and the address stable until `imem_ack`.
  - On `imem_ack`: latch `imem_rdata` into `instr` and move to EXEC.
- **EXEC**
  - `imem_req=0`, `instr_valid=1`.
  - If `stall=1`: hold all state.
  - If `stall=0`: load `pc` with `next_pc`, increment `retired`, and move to FETCH.
- `next_pc` priority:
  1. `jump`: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  2. `branch & zero`: `pc_plus4 + (sext(instr[15:0]) << 2)`.
  3. Otherwise: `pc_plus4`.
- `branch`, `jump` and `zero` are sampled only in EXEC with `stall=0`. They are ignored in FETCH.
- `imem_ack` outside FETCH is ignored.
- Arithmetic is modulo 2^ADDR_W:
  - `pc=32'hFFFF_FFFC` with no redirect wraps to `0`.
  - A branch target wraps the same way.
- `pc[1:0]` is always `00`. `RESET_PC` must be word-aligned.
- `retired` wraps from `32'hFFFF_FFFF` to `0`.

## Timing
- Reset values: state=FETCH, `pc=RESET_PC`, `instr=0`, `opcode=0`, `instr_valid=0`, `retired=0`, `imem_req=1` in the first cycle after reset, `imem_addr=RESET_PC`.
- Reset mid-operation:
  - Abandons any outstanding request.
  - An `imem_ack` in the same cycle as `reset` is ignored.
  - Reset wins over `stall`.
- Latency with same-cycle ack: 2 cycles per instruction (FETCH, EXEC).
- Each extra cycle without `imem_ack` adds one cycle. Each `stall` cycle adds one cycle.
- `instr`, `opcode`, `pc` and `pc_plus4` are constant for the whole EXEC residency, including stalls.
- `instr_valid` drops to 0 in the cycle after EXEC exits.

## Structure
- Shared package `mips_pkg`:
  - opcode constants `OP_RTYPE=6'b000000`, `OP_J=6'b000010`, `OP_BEQ=6'b000100`, `OP_ADDI=6'b001000`, `OP_SLTI=6'b001010`, `OP_LW=6'b100011`, `OP_SW=6'b101011`;
  - fetch state enum `fetch_state_t {FETCH, EXEC}`;
  - `RESET_PC_DEFAULT`.
- One sub-module, `pc_next`: combinational next-PC mux.
  - Inputs: `pc_plus4`, `instr`, `branch`, `zero`, `jump`.
  - Output: `next_pc`.
- `instr_fetch` holds the FSM, the PC register, the instruction register and the retire counter.

## Test plan
- **Reset, first fetch:** assert reset, release, ack `32'h2008_0005` in the first cycle.
  - During reset: `imem_req=1`, `imem_addr=0`.
  - Next cycle: `instr_valid=1`, `opcode=6'b001000`.
  - Then `pc=4`, `retired=1`.
- **beq:** `pc=32'h10`, `instr=32'h1000_0003`, `branch=1`.
  - `zero=1` gives `pc=32'h20`.
  - `zero=0` gives `pc=32'h14`.
  - Offset `16'hFFFF` with `zero=1` gives `pc=32'h10`.
- **Jump:** `pc=32'h10`, `instr=32'h0800_0040`, `jump=1`, `branch=1`, `zero=1` -> `pc=32'h100`, confirming jump priority.
- **Stall and wait:**
  - Hold `stall` for 3 EXEC cycles: `instr`, `pc` and `retired` are unchanged.
  - Delay `imem_ack` by 4 cycles: `imem_req` and `imem_addr` are held stable throughout.
- **Wrap:** `RESET_PC=32'hFFFF_FFFC`, no redirect -> next `imem_addr=0`.
- **Reset mid-operation:** assert `reset` during a FETCH wait, with `imem_ack` in the same cycle -> all outputs return to reset values and the instruction is not latched.
